eva_axi_rd_arb: RTL and testbench
=================================

EVA_AXI_RD_ARB -- requirements
Module: eva_axi_rd_arb

Interface
REQ-001 Parameter: MAX_OUT, default 4, maximum outstanding read bursts per requester (range 1..15).
REQ-002 aclk  in  1  clock; all logic on rising edge.
REQ-003 arest_n  in  1  reset; synchronous, active-low.
REQ-004 mN_arvalid  in  1  requester N (N=0,1) read-address valid.
REQ-005 mN_arready  out  1  requester N read-address accept.
REQ-006 mN_arid  in  3  requester N transaction ID.
REQ-007 mN_araddr  in  32  requester N burst address.
REQ-008 mN_arlen  in  6  requester N burst length minus 1.
REQ-009 mN_rvalid  out  1  read data valid to requester N.
REQ-010 mN_rready  in  1  requester N read data accept.
REQ-011 mN_rid  out  3  response ID to requester N.
REQ-012 mN_rdata  out  128  read data to requester N.
REQ-013 mN_rlast  out  1  last beat to requester N.
REQ-014 mN_rresp  out  2  response code to requester N.
REQ-015 s_arvalid, s_arready  out/in  1 each  shared slave address handshake.
REQ-016 s_arid  out  4  {grant index, mN_arid}.
REQ-017 s_araddr  out  32;  s_arlen  out  6;  captured request fields.
REQ-018 s_rvalid  in  1;  s_rready  out  1;  s_rid  in  4;  s_rdata  in  128;  s_rlast  in  1;  s_rresp  in  2.
REQ-019 err  out  1  sticky: response arrived for a requester with zero outstanding bursts.

Function
REQ-020 FSM states: IDLE, ISSUE.
REQ-021 IDLE: eligible requester = mN_arvalid=1 and cnt[N] < MAX_OUT; none eligible -> stay IDLE.
REQ-022 IDLE, one eligible -> grant it; both eligible -> grant the requester not granted last (prio bit; reset value selects m0).
REQ-023 Grant cycle: mN_arready=1 for exactly one cycle for the granted N only; id/addr/len captured into holding register; s_arid[3]=N; next state ISSUE.
REQ-024 ISSUE: s_arvalid=1, fields held stable; both mN_arready=0; on s_arvalid&s_arready -> cnt[N]+1, prio toggles to favour the other requester, next state IDLE.
REQ-025 Minimum spacing: two accepted requests at least 2 cycles apart; grant-to-s_arvalid latency 1 cycle.
REQ-026 R routing combinational: mN_rvalid = s_rvalid & (s_rid[3]==N); mN_rid=s_rid[2:0]; rdata/rlast/rresp broadcast to both.
REQ-027 s_rready = m0_rready when s_rid[3]=0, else m1_rready.
REQ-028 Beat accepted and s_rlast=1 -> cnt[s_rid[3]]-1.
REQ-029 Same-cycle increment and decrement of the same cnt -> value unchanged; different cnts -> both update.
REQ-030 cnt width 4 bits; saturates at MAX_OUT (no further grant); decrement at 0 -> cnt stays 0, err set to 1 and held until reset.
REQ-031 No combinational path from s_arready to any mN_arready.

Reset
REQ-032 arest_n=0 at a rising edge: state=IDLE, cnt[0]=cnt[1]=0, prio=m0, err=0, s_arvalid=0, mN_arready=0, holding register=0.
REQ-033 Reset during ISSUE: s_arvalid drops the cycle after the reset edge; the pending request is discarded.
REQ-034 R-path outputs follow the s_r* inputs during reset; counters do not update.

Verification
REQ-035 m0 only, arid=5, araddr=0x1000, arlen=3, s_arready=1 -> m0_arready pulse in cycle 1, s_arvalid in cycle 2 with s_arid=0x5, cnt[0]=1.
REQ-036 m0 and m1 held valid continuously, s_arready=1 -> grants alternate m0,m1,m0,m1, s_arid[3] sequence 0,1,0,1.
REQ-037 MAX_OUT=4, m0 issues 4 bursts, no responses -> 5th m0 request stalls while m1 is still granted; one s_rlast with s_rid=0x2 -> m0 granted next.
REQ-038 s_rvalid=1, s_rid=0xA, m1_rready=0 -> m1_rvalid=1, m0_rvalid=0, s_rready=0; raise m1_rready -> beat accepted.
REQ-039 Same cycle: m0 AR handshake and m0 rlast beat with cnt[0]=2 -> cnt[0] stays 2.
REQ-040 s_rlast beat for m1 with cnt[1]=0 -> err=1, cnt[1]=0; arest_n low for one edge -> err=0, s_arvalid=0.

Source files
------------

// File: rtl/eva_axi_rd_arb_if.sv
// AXI read channel bundle (AR + R) shared by the requester ports and the slave port.
// IdW is 3 on the requester side and 4 on the slave side (grant index prepended).
interface eva_axi_rd_arb_if #(
    parameter int unsigned IdW = 3
);
    logic           arvalid;
    logic           arready;
    logic [IdW-1:0] arid;
    logic [31:0]    araddr;
    logic [5:0]     arlen;
    logic           rvalid;
    logic           rready;
    logic [IdW-1:0] rid;
    logic [127:0]   rdata;
    logic           rlast;
    logic [1:0]     rresp;

    // Issues read bursts and consumes read data.
    modport master (
        output arvalid, arid, araddr, arlen, rready,
        input  arready, rvalid, rid, rdata, rlast, rresp
    );

    // Accepts read bursts and returns read data.
    modport slave (
        input  arvalid, arid, araddr, arlen, rready,
        output arready, rvalid, rid, rdata, rlast, rresp
    );
endinterface

// File: rtl/eva_axi_rd_arb.sv
// Two-requester AXI read arbiter onto one slave port. Round-robin on AR with a
// per-requester cap on outstanding bursts; R beats are routed back on s_rid[3].
module eva_axi_rd_arb #(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic             aclk,
    input  logic             arest_n,
    eva_axi_rd_arb_if.slave  m0,
    eva_axi_rd_arb_if.slave  m1,
    eva_axi_rd_arb_if.master s,
    output logic             err
);
    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    localparam logic [3:0] CntMax = 4'(MAX_OUT);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [1:0][3:0]  r_cnt;
    logic [1:0][3:0]  w_cnt_nxt;
    logic             r_prio;      // requester favoured when both are eligible
    logic             r_gnt;       // requester owning the holding register
    logic [2:0]       r_id;
    logic [31:0]      r_addr;
    logic [5:0]       r_len;
    logic             r_err;

    logic             w_elig0;
    logic             w_elig1;
    logic             w_grant_vld;
    logic             w_grant_idx;
    logic             w_issue_done;
    logic [1:0]       w_inc;
    logic [1:0]       w_dec;
    logic             w_err_set;
    logic             w_s_rready;
    logic             w_rbeat_last;

    assign w_elig0 = m0.arvalid && (r_cnt[0] < CntMax);
    assign w_elig1 = m1.arvalid && (r_cnt[1] < CntMax);

    // Arbitration and next-state decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_vld  = 1'b0;
        w_grant_idx  = 1'b0;
        w_issue_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_elig0 || w_elig1) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = (w_elig0 && w_elig1) ? r_prio : w_elig1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                if (s.arready) begin
                    w_issue_done = 1'b1;
                    w_state_nxt  = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Accept pulses depend only on state, counters and requester valids, never on
    // s_arready. Gated by reset so nothing is accepted on an edge that discards it.
    assign m0.arready = arest_n && w_grant_vld && !w_grant_idx;
    assign m1.arready = arest_n && w_grant_vld && w_grant_idx;

    assign s.arvalid = (r_state == StIssue);
    assign s.arid    = {r_gnt, r_id};
    assign s.araddr  = r_addr;
    assign s.arlen   = r_len;

    // R path is purely combinational, so it follows s_r* even while in reset.
    assign w_s_rready = s.rid[3] ? m1.rready : m0.rready;
    assign s.rready   = w_s_rready;
    assign m0.rvalid  = s.rvalid && !s.rid[3];
    assign m1.rvalid  = s.rvalid && s.rid[3];
    assign m0.rid     = s.rid[2:0];
    assign m1.rid     = s.rid[2:0];
    assign m0.rdata   = s.rdata;
    assign m1.rdata   = s.rdata;
    assign m0.rlast   = s.rlast;
    assign m1.rlast   = s.rlast;
    assign m0.rresp   = s.rresp;
    assign m1.rresp   = s.rresp;

    assign w_rbeat_last = s.rvalid && w_s_rready && s.rlast;
    assign w_inc = {w_issue_done && r_gnt, w_issue_done && !r_gnt};
    assign w_dec = {w_rbeat_last && s.rid[3], w_rbeat_last && !s.rid[3]};

    // Outstanding-burst counters: a simultaneous inc and dec cancel out.
    always_comb begin
        w_err_set = 1'b0;
        w_cnt_nxt = r_cnt;
        for (int k = 0; k < 2; k++) begin
            if (w_inc[k] && !w_dec[k]) begin
                if (r_cnt[k] < CntMax) begin
                    w_cnt_nxt[k] = r_cnt[k] + 4'd1;
                end
            end else if (w_dec[k] && !w_inc[k]) begin
                if (r_cnt[k] == 4'd0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[k] = r_cnt[k] - 4'd1;
                end
            end
        end
    end

    // State, holding register, priority, counters and sticky error.
    always_ff @(posedge aclk) begin
        if (!arest_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_prio  <= 1'b0;
            r_gnt   <= 1'b0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant_vld) begin
                r_gnt  <= w_grant_idx;
                r_id   <= w_grant_idx ? m1.arid   : m0.arid;
                r_addr <= w_grant_idx ? m1.araddr : m0.araddr;
                r_len  <= w_grant_idx ? m1.arlen  : m0.arlen;
            end
            if (w_issue_done) begin
                r_prio <= !r_gnt;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;

endmodule

// File: tb/tb_eva_axi_rd_arb.sv
// Self-checking bench for eva_axi_rd_arb: directed scenarios plus a randomized run,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_eva_axi_rd_arb;
    localparam int unsigned MaxOut = 4;

    logic aclk = 1'b0;
    logic arest_n;
    logic err;

    always #5 aclk = ~aclk;

    eva_axi_rd_arb_if #(.IdW(3)) m0_if ();
    eva_axi_rd_arb_if #(.IdW(3)) m1_if ();
    eva_axi_rd_arb_if #(.IdW(4)) s_if ();

    eva_axi_rd_arb #(.MAX_OUT(MaxOut)) dut (
        .aclk    (aclk),
        .arest_n (arest_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .err     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: outstanding counts, a one-deep pending-request slot,
    // the favoured requester and the sticky error.
    bit              model_on = 1'b0;
    int unsigned     mdl_cnt[2] = '{0, 0};
    logic            mdl_pend = 1'b0;
    logic            mdl_pg   = 1'b0;
    logic            mdl_next = 1'b0;
    logic            mdl_err  = 1'b0;
    logic [2:0]      mdl_id   = '0;
    logic [31:0]     mdl_addr = '0;
    logic [5:0]      mdl_len  = '0;

    logic e0, e1, gv, g, exp_rready, acc_issue, acc_last;
    int   rk;

    always @(negedge aclk) begin
        if (model_on) begin
            e0 = m0_if.arvalid && (mdl_cnt[0] < MaxOut);
            e1 = m1_if.arvalid && (mdl_cnt[1] < MaxOut);
            gv = arest_n && !mdl_pend && (e0 || e1);
            g  = (e0 && e1) ? mdl_next : e1;
            exp_rready = s_if.rid[3] ? m1_if.rready : m0_if.rready;

            check("m0_arready", 128'(m0_if.arready), 128'(gv && !g));
            check("m1_arready", 128'(m1_if.arready), 128'(gv && g));
            check("s_arvalid",  128'(s_if.arvalid),  128'(mdl_pend));
            check("s_arid",     128'(s_if.arid),     128'({mdl_pg, mdl_id}));
            check("s_araddr",   128'(s_if.araddr),   128'(mdl_addr));
            check("s_arlen",    128'(s_if.arlen),    128'(mdl_len));
            check("m0_rvalid",  128'(m0_if.rvalid),  128'(s_if.rvalid && !s_if.rid[3]));
            check("m1_rvalid",  128'(m1_if.rvalid),  128'(s_if.rvalid && s_if.rid[3]));
            check("m0_rid",     128'(m0_if.rid),     128'(s_if.rid[2:0]));
            check("m1_rid",     128'(m1_if.rid),     128'(s_if.rid[2:0]));
            check("m0_rdata",   m0_if.rdata,         s_if.rdata);
            check("m1_rdata",   m1_if.rdata,         s_if.rdata);
            check("m0_rlast",   128'(m0_if.rlast),   128'(s_if.rlast));
            check("m1_rlast",   128'(m1_if.rlast),   128'(s_if.rlast));
            check("m0_rresp",   128'(m0_if.rresp),   128'(s_if.rresp));
            check("m1_rresp",   128'(m1_if.rresp),   128'(s_if.rresp));
            check("s_rready",   128'(s_if.rready),   128'(exp_rready));
            check("err",        128'(err),           128'(mdl_err));

            // Advance the model to the state after the coming rising edge.
            if (!arest_n) begin
                mdl_cnt  = '{0, 0};
                mdl_pend = 1'b0;
                mdl_pg   = 1'b0;
                mdl_next = 1'b0;
                mdl_err  = 1'b0;
                mdl_id   = '0;
                mdl_addr = '0;
                mdl_len  = '0;
            end else begin
                acc_issue = mdl_pend && s_if.arready;
                acc_last  = s_if.rvalid && exp_rready && s_if.rlast;
                rk        = s_if.rid[3] ? 1 : 0;
                if (acc_issue && acc_last && (rk == int'(mdl_pg))) begin
                    // net zero change
                end else begin
                    if (acc_issue && mdl_cnt[mdl_pg] < MaxOut) mdl_cnt[mdl_pg]++;
                    if (acc_last) begin
                        if (mdl_cnt[rk] == 0) mdl_err = 1'b1;
                        else mdl_cnt[rk]--;
                    end
                end
                if (acc_issue) begin
                    mdl_pend = 1'b0;
                    mdl_next = !mdl_pg;
                end
                if (gv) begin
                    mdl_pend = 1'b1;
                    mdl_pg   = g;
                    mdl_id   = g ? m1_if.arid   : m0_if.arid;
                    mdl_addr = g ? m1_if.araddr : m0_if.araddr;
                    mdl_len  = g ? m1_if.arlen  : m0_if.arlen;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_if.arvalid = 1'b0; m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0;
        m0_if.rready  = 1'b0;
        m1_if.arvalid = 1'b0; m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0;
        m1_if.rready  = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rid = '0; s_if.rdata = '0;
        s_if.rlast   = 1'b0; s_if.rresp  = '0;
    endtask

    task automatic do_reset();
        arest_n = 1'b0;
        clear_inputs();
        tick();
        arest_n = 1'b1;
    endtask

    typedef struct packed {
        logic [3:0] id;
        logic [5:0] len;
    } burst_t;

    burst_t rq[$];
    int     seq[$];
    int     beat;
    int     npulse;
    logic   hs0, hs1, shs, rhs;

    initial begin
        arest_n = 1'b0;
        clear_inputs();
        tick();
        model_on = 1'b1;

        // Single m0 request: grant in cycle 1, issue in cycle 2.
        do_reset();
        m0_if.arvalid = 1'b1; m0_if.arid = 3'd5; m0_if.araddr = 32'h1000; m0_if.arlen = 6'd3;
        s_if.arready = 1'b1;
        #3;
        check("t1_m0_arready_c1", 128'(m0_if.arready), 128'(1));
        check("t1_s_arvalid_c1",  128'(s_if.arvalid),  128'(0));
        tick();
        m0_if.arvalid = 1'b0;
        #3;
        check("t1_s_arvalid_c2", 128'(s_if.arvalid), 128'(1));
        check("t1_s_arid_c2",    128'(s_if.arid),    128'(4'h5));
        check("t1_s_araddr_c2",  128'(s_if.araddr),  128'(32'h1000));
        check("t1_s_arlen_c2",   128'(s_if.arlen),   128'(6'd3));
        check("t1_m0_arready_c2", 128'(m0_if.arready), 128'(0));
        tick();
        #3;
        check("t1_s_arvalid_c3", 128'(s_if.arvalid), 128'(0));
        check("t1_model_cnt0",   128'(mdl_cnt[0]),   128'(1));

        // Both requesters continuously valid: grants alternate starting with m0.
        do_reset();
        s_if.arready = 1'b1;
        m0_if.arvalid = 1'b1; m0_if.arid = 3'd1;
        m1_if.arvalid = 1'b1; m1_if.arid = 3'd6;
        seq.delete();
        for (int c = 0; c < 8; c++) begin
            #3;
            if (s_if.arvalid) seq.push_back(int'(s_if.arid[3]));
            tick();
        end
        check("t2_grant_count", 128'(seq.size()), 128'(4));
        for (int i = 0; i < seq.size(); i++) begin
            check("t2_grant_order", 128'(seq[i]), 128'(i % 2));
        end
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;

        // m0 saturates at MaxOut; m1 still served; one m0 completion frees a slot.
        do_reset();
        s_if.arready = 1'b1;
        m0_if.arvalid = 1'b1; m0_if.arid = 3'd2;
        repeat (8) tick();
        m1_if.arvalid = 1'b1; m1_if.arid = 3'd4;
        #3;
        check("t3_m0_stall",     128'(m0_if.arready), 128'(0));
        check("t3_m1_granted",   128'(m1_if.arready), 128'(1));
        check("t3_model_cnt0",   128'(mdl_cnt[0]),    128'(4));
        tick();
        m1_if.arvalid = 1'b0;
        tick();
        s_if.rvalid = 1'b1; s_if.rid = 4'h2; s_if.rlast = 1'b1; m0_if.rready = 1'b1;
        #3;
        check("t3_m0_still_stall", 128'(m0_if.arready), 128'(0));
        check("t3_m0_rvalid",      128'(m0_if.rvalid),  128'(1));
        tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        #3;
        check("t3_m0_regranted", 128'(m0_if.arready), 128'(1));
        check("t3_model_cnt0b",  128'(mdl_cnt[0]),    128'(3));
        tick();
        m0_if.arvalid = 1'b0;
        tick();

        // R routing with back-pressure from m1.
        do_reset();
        s_if.rvalid = 1'b1; s_if.rid = 4'hA; s_if.rdata = {4{32'hCAFE_F00D}}; s_if.rresp = 2'd2;
        #3;
        check("t4_m1_rvalid", 128'(m1_if.rvalid), 128'(1));
        check("t4_m0_rvalid", 128'(m0_if.rvalid), 128'(0));
        check("t4_s_rready0", 128'(s_if.rready),  128'(0));
        check("t4_m1_rid",    128'(m1_if.rid),    128'(3'd2));
        m1_if.rready = 1'b1;
        #1;
        check("t4_s_rready1", 128'(s_if.rready), 128'(1));
        tick();
        s_if.rvalid = 1'b0;

        // Same-cycle issue and completion for m0 with two outstanding.
        do_reset();
        s_if.arready = 1'b1;
        m0_if.arvalid = 1'b1; m0_if.arid = 3'd7;
        repeat (4) tick();
        tick();
        m0_if.arvalid = 1'b0;
        s_if.rvalid = 1'b1; s_if.rid = 4'h7; s_if.rlast = 1'b1; m0_if.rready = 1'b1;
        #3;
        check("t5_s_arvalid", 128'(s_if.arvalid), 128'(1));
        check("t5_s_rready",  128'(s_if.rready),  128'(1));
        tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        #3;
        check("t5_model_cnt0", 128'(mdl_cnt[0]), 128'(2));
        m0_if.arvalid = 1'b1;
        npulse = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (m0_if.arready) npulse++;
            tick();
        end
        check("t5_free_slots", 128'(npulse), 128'(2));
        m0_if.arvalid = 1'b0;

        // Completion with nothing outstanding, then reset in the middle of an issue.
        do_reset();
        s_if.rvalid = 1'b1; s_if.rid = 4'h8; s_if.rlast = 1'b1; m1_if.rready = 1'b1;
        tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        #3;
        check("t6_err_set",     128'(err),         128'(1));
        check("t6_model_cnt1",  128'(mdl_cnt[1]),  128'(0));
        tick();
        m0_if.arvalid = 1'b1; m0_if.arid = 3'd3; s_if.arready = 1'b0;
        tick();
        m0_if.arvalid = 1'b0;
        #3;
        check("t6_s_arvalid_pend", 128'(s_if.arvalid), 128'(1));
        arest_n = 1'b0;
        m0_if.arvalid = 1'b1;
        #1;
        check("t6_arready_in_rst", 128'(m0_if.arready), 128'(0));
        tick();
        arest_n = 1'b1;
        m0_if.arvalid = 1'b0;
        #3;
        check("t6_s_arvalid_drop", 128'(s_if.arvalid), 128'(0));
        check("t6_err_cleared",    128'(err),          128'(0));
        check("t6_model_cnt0",     128'(mdl_cnt[0]),   128'(0));
        tick();

        // Randomized traffic; the slave answers only bursts it has accepted, in order.
        do_reset();
        rq.delete();
        beat = 0;
        hs0 = 1'b0; hs1 = 1'b0; shs = 1'b0; rhs = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (hs0 || !m0_if.arvalid) begin
                m0_if.arvalid = ($urandom_range(0, 3) != 0);
                m0_if.arid    = 3'($urandom);
                m0_if.araddr  = $urandom;
                m0_if.arlen   = 6'($urandom_range(0, 3));
            end
            if (hs1 || !m1_if.arvalid) begin
                m1_if.arvalid = ($urandom_range(0, 3) != 0);
                m1_if.arid    = 3'($urandom);
                m1_if.araddr  = $urandom;
                m1_if.arlen   = 6'($urandom_range(0, 3));
            end
            m0_if.rready = ($urandom_range(0, 3) != 0);
            m1_if.rready = ($urandom_range(0, 3) != 0);
            s_if.arready = ($urandom_range(0, 1) != 0);
            if (rhs) begin
                if (s_if.rlast) begin
                    void'(rq.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
                s_if.rvalid = 1'b0;
                s_if.rlast  = 1'b0;
            end
            if (!s_if.rvalid && rq.size() > 0 && $urandom_range(0, 2) != 0) begin
                s_if.rvalid = 1'b1;
                s_if.rid    = rq[0].id;
                s_if.rdata  = {$urandom, $urandom, $urandom, $urandom};
                s_if.rlast  = (beat == int'(rq[0].len));
                s_if.rresp  = 2'($urandom);
            end
            @(negedge aclk);
            hs0 = m0_if.arvalid && m0_if.arready;
            hs1 = m1_if.arvalid && m1_if.arready;
            shs = s_if.arvalid && s_if.arready;
            rhs = s_if.rvalid && s_if.rready;
            if (shs) rq.push_back('{id: s_if.arid, len: s_if.arlen});
            tick();
        end

        clear_inputs();
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
